// File: rtl/axil_imem_loader.sv
// AXI4-Lite master that turns single valid/ready load/readback commands into
// AW/W/B or AR/R transactions, returning status plus a saturating latency.
module axil_imem_loader #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LAT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [LAT_W-1:0]      rsp_lat,
  output logic                  m_aresetn,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  we_q, we_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic                  aresetn_q;

  // Ready only once the slave is out of reset too, so no command races m_aresetn.
  assign cmd_ready = (state_q == IDLE) && aresetn_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    lat_d     = lat_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          we_d    = cmd_we;
          lat_d   = '0;
          if (cmd_we) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        // AW and W retire independently; a channel already done counts as complete.
        awvalid_d = awvalid_q && !m_axi_awready;
        wvalid_d  = wvalid_q && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      READ: begin
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == WRITE || state_q == WRESP || state_q == READ || state_q == RDATA)
        && (lat_q != '1)) begin
      lat_d = lat_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      lat_q     <= '0;
      aresetn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      lat_q     <= lat_d;
      aresetn_q <= 1'b1;
    end
  end

  assign m_aresetn     = aresetn_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == READ);
  assign m_axi_rready  = (state_q == RDATA);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_we        = we_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_lat       = lat_q;

endmodule

// File: tb/tb_axil_imem_loader.sv
// Randomised bench for axil_imem_loader: AXI-Lite slave with memory, per-cycle
// transaction-level reference model, plus directed literal scenarios.
module tb_axil_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_we, m_aresetn;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  rsp_lat;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  // Second copy with a 4-bit latency counter, fed identical stimulus.
  logic        cmd_ready4, rsp_valid4, rsp_we4, m_aresetn4;
  logic [31:0] rsp_rdata4, awaddr4, wdata4, araddr4;
  logic [1:0]  rsp_resp4;
  logic [3:0]  rsp_lat4, wstrb4;
  logic        awvalid4, wvalid4, bready4, arvalid4, rready4;

  axil_imem_loader #(.ADDR_W(32), .DATA_W(32), .LAT_W(8)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_lat(rsp_lat), .m_aresetn(m_aresetn),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  axil_imem_loader #(.ADDR_W(32), .DATA_W(32), .LAT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_we(rsp_we4), .rsp_rdata(rsp_rdata4),
    .rsp_resp(rsp_resp4), .rsp_lat(rsp_lat4), .m_aresetn(m_aresetn4),
    .m_axi_awaddr(awaddr4), .m_axi_awvalid(awvalid4), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(wdata4), .m_axi_wstrb(wstrb4), .m_axi_wvalid(wvalid4),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(bready4), .m_axi_araddr(araddr4), .m_axi_arvalid(arvalid4),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(rready4)
  );

  int unsigned n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] defval(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // ---------------- AXI-Lite slave with backing memory ----------------
  logic [31:0] smem [logic [31:0]];
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_gap = 1, r_gap = 1;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int          aw_n = 0, w_n = 0, b_n = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0;

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : defval(a);
  endfunction

  initial begin
    int aw_c, w_c, ar_c, b_i, r_i;
    bit aw_g, w_g, bp, rp, awh, wh, bh, arh, rh, awv, wv, arv;
    logic [31:0] sa, sd, ra, t_aw, t_w, t_ar;
    logic [3:0] ss, t_s;
    aw_c = 0; w_c = 0; ar_c = 0; b_i = 0; r_i = 0;
    aw_g = 0; w_g = 0; bp = 0; rp = 0;
    sa = '0; sd = '0; ra = '0; ss = '0;
    forever begin
      @(negedge clk);
      awv = m_axi_awvalid; wv = m_axi_wvalid; arv = m_axi_arvalid;
      awh = m_axi_awvalid && m_axi_awready;
      wh  = m_axi_wvalid && m_axi_wready;
      bh  = m_axi_bvalid && m_axi_bready;
      arh = m_axi_arvalid && m_axi_arready;
      rh  = m_axi_rvalid && m_axi_rready;
      t_aw = m_axi_awaddr; t_w = m_axi_wdata; t_s = m_axi_wstrb; t_ar = m_axi_araddr;
      @(posedge clk); #1;
      if (!m_aresetn) begin
        aw_c = 0; w_c = 0; ar_c = 0; aw_g = 0; w_g = 0; bp = 0; rp = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        continue;
      end
      if (awh) begin aw_g = 1; sa = t_aw; aw_c = 0; aw_n++; last_awaddr = t_aw; end
      else if (awv) aw_c++;
      if (wh) begin w_g = 1; sd = t_w; ss = t_s; w_c = 0; w_n++; last_wdata = t_w; end
      else if (wv) w_c++;
      if (bh) begin m_axi_bvalid = 0; bp = 0; b_n++; end
      if (aw_g && w_g) begin
        smem[sa] = merge(srd(sa), sd, ss);
        aw_g = 0; w_g = 0; bp = 1; b_i = 0;
      end
      if (bp && !m_axi_bvalid) begin
        b_i++;
        if (b_i >= b_gap) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
      end
      if (rh) begin m_axi_rvalid = 0; rp = 0; end
      if (arh) begin ra = t_ar; ar_c = 0; rp = 1; r_i = 0; end
      else if (arv) ar_c++;
      if (rp && !m_axi_rvalid) begin
        r_i++;
        if (r_i >= r_gap) begin m_axi_rvalid = 1; m_axi_rdata = srd(ra); m_axi_rresp = rresp_cfg; end
      end
      m_axi_awready = m_axi_awvalid && (aw_c >= aw_dly);
      m_axi_wready  = m_axi_wvalid && (w_c >= w_dly);
      m_axi_arready = m_axi_arvalid && (ar_c >= ar_dly);
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] rmem [logic [31:0]];
  bit          m_busy = 0, m_pend = 0, m_we = 0, m_awd = 0, m_wd = 0, m_ard = 0;
  bit          m_aresetn_exp = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_exp_rdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [1:0]  m_exp_resp = '0;
  int          m_lat = 0;

  function automatic logic [31:0] rrd(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : defval(a);
  endfunction

  // At each falling edge: compare DUT state with the model, then advance the
  // model across the coming rising edge using the now-stable inputs.
  always @(negedge clk) begin
    chk("m_aresetn", m_aresetn, m_aresetn_exp);
    chk("cmd_ready", cmd_ready, m_aresetn_exp && !m_busy && !m_pend);
    chk("awvalid", m_axi_awvalid, m_busy && m_we && !m_awd);
    chk("wvalid", m_axi_wvalid, m_busy && m_we && !m_wd);
    chk("bready", m_axi_bready, m_busy && m_we && m_awd && m_wd);
    chk("arvalid", m_axi_arvalid, m_busy && !m_we && !m_ard);
    chk("rready", m_axi_rready, m_busy && !m_we && m_ard);
    chk("rsp_valid", rsp_valid, m_pend);
    chk("rsp_valid4", rsp_valid4, m_pend);
    chk("cmd_ready4", cmd_ready4, m_aresetn_exp && !m_busy && !m_pend);
    if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, m_addr);
    if (m_axi_wvalid) begin
      chk("wdata", m_axi_wdata, m_wdata);
      chk("wstrb", m_axi_wstrb, m_wstrb);
    end
    if (m_axi_arvalid) chk("araddr", m_axi_araddr, m_addr);
    if (m_pend) begin
      chk("rsp_we", rsp_we, m_we);
      chk("rsp_rdata", rsp_rdata, m_exp_rdata);
      chk("rsp_resp", rsp_resp, m_exp_resp);
      chk("rsp_lat", rsp_lat, (m_lat > 255) ? 255 : m_lat);
      chk("rsp_lat4", rsp_lat4, (m_lat > 15) ? 15 : m_lat);
    end
    if (rst) begin
      m_busy = 0; m_pend = 0; m_awd = 0; m_wd = 0; m_ard = 0; m_aresetn_exp = 0;
    end else begin
      if (m_pend && rsp_valid && rsp_ready) m_pend = 0;
      if (m_busy) begin
        m_lat++;
        if (m_axi_awvalid && m_axi_awready) m_awd = 1;
        if (m_axi_wvalid && m_axi_wready) m_wd = 1;
        if (m_axi_bvalid && m_axi_bready) begin
          m_busy = 0; m_pend = 1; m_exp_rdata = '0; m_exp_resp = m_axi_bresp;
        end
        if (m_axi_arvalid && m_axi_arready) m_ard = 1;
        if (m_axi_rvalid && m_axi_rready) begin
          m_busy = 0; m_pend = 1; m_exp_rdata = rrd(m_addr); m_exp_resp = m_axi_rresp;
        end
      end
      if (cmd_valid && cmd_ready) begin
        m_busy = 1; m_we = cmd_we; m_addr = cmd_addr; m_wdata = cmd_wdata; m_wstrb = cmd_wstrb;
        m_awd = 0; m_wd = 0; m_ard = 0; m_lat = 0;
        if (cmd_we) rmem[cmd_addr] = merge(rrd(cmd_addr), cmd_wdata, cmd_wstrb);
      end
      m_aresetn_exp = 1;
    end
  end

  // ---------------- command / response driver ----------------
  task automatic do_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, input bit poke,
                        output logic [31:0] rd, output logic [1:0] rs, output logic [7:0] lt,
                        output logic [3:0] lt4, output logic rwe);
    int n;
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    n = 0;
    while (!rsp_valid && n < 400) begin @(posedge clk); #1; n++; end
    chk("rsp_arrive", rsp_valid, 1'b1);
    if (poke) cmd_valid = 1;
    repeat (hold) begin @(posedge clk); #1; end
    rd = rsp_rdata; rs = rsp_resp; lt = rsp_lat; lt4 = rsp_lat4; rwe = rsp_we;
    cmd_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [7:0]  lt;
    logic [3:0]  lt4;
    logic        rwe;
    int          b0, n;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_aresetn", m_aresetn, 1'b0);
    chk("reset_rsp_lat", rsp_lat, 8'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_awaddr", m_axi_awaddr, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    chk("aresetn_release", m_aresetn, 1'b1);

    // Write, always-ready slave
    b0 = aw_n;
    do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, rd, rs, lt, lt4, rwe);
    chk("wr_lat", lt, 8'd2);
    chk("wr_resp", rs, 2'b00);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_aw_count", aw_n - b0, 1);
    chk("wr_awaddr_seen", last_awaddr, 32'h10);
    chk("wr_wdata_seen", last_wdata, 32'hDEADBEEF);

    // Write with W accepted three cycles before AW
    aw_dly = 3; w_dly = 0; b0 = b_n;
    do_cmd(1'b1, 32'h14, 32'h12345678, 4'hF, 0, 1'b0, rd, rs, lt, lt4, rwe);
    chk("skew_lat", lt, 8'd5);
    chk("skew_b_count", b_n - b0, 1);
    aw_dly = 0;

    // Read back, arready after 2 wait cycles, rvalid 4 cycles after AR
    ar_dly = 2; r_gap = 4;
    do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, rs, lt, lt4, rwe);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_we", rwe, 1'b0);
    chk("rd_lat", lt, 8'd7);
    ar_dly = 0; r_gap = 1;

    // SLVERR with response backpressure while a new command is offered
    bresp_cfg = 2'b10;
    do_cmd(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, 5, 1'b1, rd, rs, lt, lt4, rwe);
    chk("err_resp", rs, 2'b10);
    chk("err_lat", lt, 8'd2);
    bresp_cfg = 2'b00;

    // Latency saturation on the 4-bit copy
    r_gap = 40;
    do_cmd(1'b0, 32'h14, 32'h0, 4'h0, 0, 1'b0, rd, rs, lt, lt4, rwe);
    chk("sat_lat8", lt, 8'd41);
    chk("sat_lat4", lt4, 4'd15);
    chk("sat_rdata", rd, 32'h12345678);

    // Reset while waiting in RDATA
    r_gap = 30;
    cmd_valid = 1; cmd_we = 0; cmd_addr = 32'h10;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    while (!m_axi_rready && n < 200) begin @(posedge clk); #1; n++; end
    chk("rst_reached_rdata", m_axi_rready, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_awvalid", m_axi_awvalid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_aresetn", m_aresetn, 1'b0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_aresetn_back", m_aresetn, 1'b1);
    r_gap = 1;
    do_cmd(1'b1, 32'h30, 32'h0BADC0DE, 4'hF, 0, 1'b0, rd, rs, lt, lt4, rwe);
    chk("post_rst_lat", lt, 8'd2);
    chk("post_rst_resp", rs, 2'b00);

    // Randomised traffic over a small address window
    for (int t = 0; t < 80; t++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      b_gap = $urandom_range(1, 4); r_gap = $urandom_range(1, 4);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      do_cmd(1'($urandom), 32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom),
             $urandom_range(0, 3), 1'($urandom), rd, rs, lt, lt4, rwe);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_imem_loader.md
Name: axil_imem_loader

Overview:
- AXI4-Lite master (initiator) that drives the AXI4-Lite slave port of the instruction memory.
- Lets a host-side controller (debug loader or boot sequencer) write program words into IMemory and read them back before releasing the CPU.
- Converts a simple single-command valid/ready request interface into AXI4-Lite write (AW/W/B) and read (AR/R) transactions.
- One outstanding transaction at a time. Each transaction returns a response carrying status and measured latency.

Parameters:
- ADDR_W, 32, AXI address width; the command address is passed through unmodified.
- DATA_W, 32, AXI data width; strobe width is DATA_W/8.
- LAT_W, 8, width of the saturating latency counter reported per response.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_we  out  1  echo of cmd_we for this response.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- rsp_lat  out  LAT_W  cycles from command accept to B/R handshake, saturating.
- m_aresetn  out  1  registered ~rst; drives the slave's s_aresetn.
- m_axi_awaddr  out  ADDR_W;  m_axi_awvalid  out  1;  m_axi_awready  in  1.
- m_axi_wdata  out  DATA_W;  m_axi_wstrb  out  DATA_W/8;  m_axi_wvalid  out  1;  m_axi_wready  in  1.
- m_axi_bresp  in  2;  m_axi_bvalid  in  1;  m_axi_bready  out  1.
- m_axi_araddr  out  ADDR_W;  m_axi_arvalid  out  1;  m_axi_arready  in  1.
- m_axi_rdata  in  DATA_W;  m_axi_rresp  in  2;  m_axi_rvalid  in  1;  m_axi_rready  out  1.

Behaviour:
- Reset (rst=1 at an edge) values:
  - FSM=IDLE.
  - All *valid, bready, rready, rsp_valid = 0.
  - cmd_ready=0 during reset, 1 from the first cycle after.
  - Data/address/rsp registers = 0; rsp_lat=0; m_aresetn=0.
- m_aresetn goes 1 one cycle after rst deasserts.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - cmd_ready=1 (and m_aresetn=1).
  - On accept: register addr/wdata/wstrb/we; clear latency counter to 0.
  - we=1 -> WRITE: assert awvalid and wvalid next cycle.
  - we=0 -> READ: assert arvalid next cycle.
- WRITE:
  - awvalid and wvalid are independent. Each drops the cycle after its own handshake. Either order, or the same cycle, is legal.
  - When both have completed -> WRESP with bready=1.
  - Payloads hold stable while valid is high.
- WRESP:
  - On bvalid&&bready: capture bresp into rsp_resp; rsp_rdata=0; bready=0 -> RESP.
- READ:
  - arvalid held until arready. Then arvalid=0, rready=1 -> RDATA.
- RDATA:
  - On rvalid&&rready: capture rdata and rresp; rready=0 -> RESP.
- RESP:
  - rsp_valid=1 with rsp_* stable until rsp_ready. Then -> IDLE.
  - cmd_ready=0 while not in IDLE; minimum of 1 idle cycle between commands.
- Valid-signal rules:
  - No valid is ever combinationally dependent on its ready.
  - A valid never drops before its handshake.
- Latency counter:
  - Increments every cycle from accept until the B/R handshake cycle, inclusive.
  - Saturates at 2^LAT_W-1.
  - Frozen in RESP.
  - Minimum value 2 (slave ready at all times).
- rsp_resp is never interpreted; SLVERR/DECERR pass through verbatim.
- Reset mid-transaction: immediate return to reset state on the next edge. m_aresetn=0 resets the slave in the same window, so no dangling handshake remains.

Test Plan:
- Write with always-ready slave:
  - Stimulus: cmd write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: AW/W both seen once with those values; rsp_resp=0, rsp_rdata=0, rsp_lat=2; cmd_ready=0 until RESP is consumed.
- Write, skewed channels:
  - Stimulus: wready asserted 3 cycles before awready.
  - Required: wvalid drops after its handshake while awvalid stays high; bready rises only after both handshakes; exactly one B is consumed.
- Read back:
  - Stimulus: read addr=0x10; slave delays arready by 2 and rvalid by 4.
  - Required: rsp_rdata=0xDEADBEEF, rsp_we=0, rsp_lat=7, araddr stable throughout.
- Error and backpressure:
  - Stimulus: slave returns bresp=2'b10; rsp_ready held 0 for 5 cycles.
  - Required: rsp_resp=2'b10; rsp_valid and rsp_* stable for all 5 cycles; no new cmd accepted.
- Saturation:
  - Stimulus: LAT_W=4; rvalid delayed 40 cycles.
  - Required: rsp_lat=15.
- Reset mid-read:
  - Stimulus: rst pulsed while in RDATA.
  - Required: next cycle all valids, rready and rsp_valid = 0, m_aresetn=0; after release, m_aresetn=1 one cycle later; a fresh write completes normally.
